// File: rtl/frame_capture_pkg.sv
// frame_capture shared FSM encoding and default sizes.
// Offset-binary input option: FRAME_CAPTURE_OFFSET_BIN_EN.
package frame_capture_pkg;

  localparam int DEF_SINK_WIDTH = 14;
  localparam int DEF_FFT_DEPTH  = 11;
  localparam int DEF_RUNS       = 3;

  typedef enum logic [1:0] {
    IDLE,
    CAPTURE,
    STREAM,
    FINISH
  } state_t;

endpackage

// File: rtl/frame_capture_ram.sv
// frame_ram: simple dual-port frame buffer with registered read.
// Read register clears on reset; stored words are never cleared.
module frame_ram
  import frame_capture_pkg::*;
#(
  parameter int WIDTH = DEF_SINK_WIDTH,
  parameter int DEPTH = DEF_FFT_DEPTH
) (
  input  logic             clk,
  input  logic             i_rst,
  input  logic             i_we,
  input  logic [DEPTH-1:0] i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_re,
  input  logic [DEPTH-1:0] i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [2**DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge clk) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/frame_capture.sv
// frame_capture: buffers N-sample frames and streams them out RUNS times.
// Define FRAME_CAPTURE_OFFSET_BIN_EN for offset-binary sink samples.
module frame_capture
  import frame_capture_pkg::*;
#(
  parameter int SINK_WIDTH = DEF_SINK_WIDTH,
  parameter int FFT_DEPTH  = DEF_FFT_DEPTH,
  parameter int RUNS       = DEF_RUNS
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       sample_en,
  input  logic [SINK_WIDTH-1:0]      sink,
  input  logic                       start,
  output logic [SINK_WIDTH-1:0]      src_data,
  output logic                       src_valid,
  output logic                       src_sop,
  output logic                       src_eop,
  input  logic                       src_ready,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(RUNS+1)-1:0]  run_idx
);

  localparam int RW = $clog2(RUNS + 1);
  localparam logic [FFT_DEPTH-1:0] LAST = '1;
  localparam logic [RW-1:0] RUN_LAST = RW'(RUNS - 1);

  state_t r_state;
  state_t w_state_nxt;

  logic [FFT_DEPTH-1:0]  r_wr_addr;
  logic [FFT_DEPTH-1:0]  r_rd_addr;
  logic                  r_rd_last;
  logic                  r_valid;
  logic                  r_sop;
  logic                  r_eop;
  logic [RW-1:0]         r_run_idx;
  logic [SINK_WIDTH-1:0] w_wdata;
  logic                  w_we;
  logic                  w_re;
  logic                  w_adv;
  logic                  w_start;
  logic                  w_cap_last;
  logic                  w_eop_xfer;

`ifdef FRAME_CAPTURE_OFFSET_BIN_EN
  assign w_wdata = {~sink[SINK_WIDTH-1], sink[SINK_WIDTH-2:0]};
`else
  assign w_wdata = sink;
`endif

  assign w_start    = (r_state == IDLE) && start;
  assign w_we       = (r_state == CAPTURE) && sample_en;
  assign w_cap_last = w_we && (r_wr_addr == LAST);
  assign w_eop_xfer = r_valid && src_ready && r_eop;
  // The read port doubles as the output register, so it only
  // advances when the current word is empty or being taken.
  assign w_adv      = !r_valid || src_ready;
  assign w_re       = (r_state == STREAM) && w_adv && !r_rd_last;

  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:    if (start) w_state_nxt = CAPTURE;
      CAPTURE: if (w_cap_last) w_state_nxt = STREAM;
      STREAM: begin
        if (w_eop_xfer)
          w_state_nxt = (r_run_idx < RUN_LAST) ? CAPTURE : FINISH;
      end
      FINISH:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_addr <= '0;
      r_rd_addr <= '0;
      r_rd_last <= 1'b0;
      r_run_idx <= '0;
      r_valid   <= 1'b0;
      r_sop     <= 1'b0;
      r_eop     <= 1'b0;
    end else begin
      if (w_start) begin
        r_wr_addr <= '0;
        r_run_idx <= '0;
      end else if (w_we) begin
        r_wr_addr <= r_wr_addr + 1'b1;
      end
      if (w_re) begin
        r_valid   <= 1'b1;
        r_sop     <= (r_rd_addr == '0);
        r_eop     <= (r_rd_addr == LAST);
        r_rd_addr <= r_rd_addr + 1'b1;
        r_rd_last <= (r_rd_addr == LAST);
      end else if (w_adv) begin
        r_valid <= 1'b0;
        r_sop   <= 1'b0;
        r_eop   <= 1'b0;
      end
      if (w_eop_xfer) begin
        r_rd_last <= 1'b0;
        if (r_run_idx < RUN_LAST) r_run_idx <= r_run_idx + 1'b1;
      end
      if (r_state == FINISH) r_run_idx <= '0;
    end
  end

  frame_ram #(
    .WIDTH (SINK_WIDTH),
    .DEPTH (FFT_DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_rst   (reset),
    .i_we    (w_we),
    .i_waddr (r_wr_addr),
    .i_wdata (w_wdata),
    .i_re    (w_re),
    .i_raddr (r_rd_addr),
    .o_rdata (src_data)
  );

  assign src_valid = r_valid;
  assign src_sop   = r_sop;
  assign src_eop   = r_eop;
  assign busy      = (r_state != IDLE);
  assign done      = (r_state == FINISH);
  assign run_idx   = r_run_idx;

endmodule

// File: tb/tb_frame_capture.sv
// Bench for frame_capture with N=8, RUNS=2: directed cases plus
// random traffic against a frame-level reference model.
module tb_frame_capture;

  localparam int W    = 14;
  localparam int D    = 3;
  localparam int N    = 8;
  localparam int RUNS = 2;
  localparam int RW   = $clog2(RUNS + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          sample_en;
  logic [W-1:0]  sink;
  logic          start;
  logic [W-1:0]  src_data;
  logic          src_valid;
  logic          src_sop;
  logic          src_eop;
  logic          src_ready;
  logic          busy;
  logic          done;
  logic [RW-1:0] run_idx;

  int errs   = 0;
  int checks = 0;
  int cyc    = 0;

  always #5 clk = ~clk;

  frame_capture #(
    .SINK_WIDTH (W),
    .FFT_DEPTH  (D),
    .RUNS       (RUNS)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sample_en (sample_en),
    .sink      (sink),
    .start     (start),
    .src_data  (src_data),
    .src_valid (src_valid),
    .src_sop   (src_sop),
    .src_eop   (src_eop),
    .src_ready (src_ready),
    .busy      (busy),
    .done      (done),
    .run_idx   (run_idx)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [W-1:0] conv(input logic [W-1:0] s);
`ifdef FRAME_CAPTURE_OFFSET_BIN_EN
    return W'(int'(s) - (1 << (W - 1)));
`else
    return s;
`endif
  endfunction

  // Reference model: phase of the sequence and captured frame
  typedef enum {M_IDLE, M_CAP, M_STR, M_FIN} mmode_t;
  mmode_t       m_mode = M_IDLE;
  int           m_cap  = 0;
  int           m_run  = 0;
  int           m_scyc = 0;
  int           m_xfer = 0;
  logic [W-1:0] m_frame [N];

  logic         p_valid = 1'b0;
  logic         p_ready = 1'b0;
  logic         p_sop   = 1'b0;
  logic         p_eop   = 1'b0;
  logic [W-1:0] p_data  = '0;

  int done_cnt = 0;
  int log_d[$];
  int log_sop[$];
  int log_eop[$];
  int log_run[$];
  int log_cyc[$];

  always @(negedge clk) begin
    cyc++;
    chk("busy", int'(busy), int'(m_mode != M_IDLE));
    chk("done", int'(done), int'(m_mode == M_FIN));
    if (m_mode != M_FIN) chk("run_idx", int'(run_idx), m_run);
    if (m_mode != M_STR)  chk("valid_off", int'(src_valid), 0);
    else if (m_scyc >= 2) chk("valid_lat", int'(src_valid), 1);
    if (p_valid && !p_ready) begin
      chk("hold_valid", int'(src_valid), 1);
      chk("hold_data", int'(src_data), int'(p_data));
      chk("hold_sop", int'(src_sop), int'(p_sop));
      chk("hold_eop", int'(src_eop), int'(p_eop));
    end
    if (src_valid && src_ready) begin
      if (m_mode == M_STR && m_xfer < N) begin
        chk("data", int'(src_data), int'(m_frame[m_xfer]));
        chk("sop", int'(src_sop), int'(m_xfer == 0));
        chk("eop", int'(src_eop), int'(m_xfer == N - 1));
      end else begin
        chk("xfer_outside_stream", 1, 0);
      end
      log_d.push_back(int'(src_data));
      log_sop.push_back(int'(src_sop));
      log_eop.push_back(int'(src_eop));
      log_run.push_back(int'(run_idx));
      log_cyc.push_back(cyc);
    end
    if (done) done_cnt++;

    p_valid = src_valid;
    p_ready = src_ready;
    p_sop   = src_sop;
    p_eop   = src_eop;
    p_data  = src_data;
    if (reset) begin
      m_mode  = M_IDLE;
      m_run   = 0;
      m_cap   = 0;
      p_valid = 1'b0;
    end else begin
      case (m_mode)
        M_IDLE: if (start) begin
          m_mode = M_CAP;
          m_run  = 0;
          m_cap  = 0;
        end
        M_CAP: if (sample_en) begin
          m_frame[m_cap] = conv(sink);
          m_cap++;
          if (m_cap == N) begin
            m_mode = M_STR;
            m_scyc = 0;
            m_xfer = 0;
          end
        end
        M_STR: begin
          m_scyc++;
          if (src_valid && src_ready) begin
            m_xfer++;
            if (m_xfer == N) begin
              if (m_run < RUNS - 1) begin
                m_run++;
                m_mode = M_CAP;
                m_cap  = 0;
              end else begin
                m_mode = M_FIN;
              end
            end
          end
        end
        M_FIN: begin
          m_mode = M_IDLE;
          m_run  = 0;
        end
        default: m_mode = M_IDLE;
      endcase
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int base);
    for (int i = 0; i < N; i++) begin
      sample_en = 1'b1;
      sink      = W'(base + i);
      tick();
    end
    sample_en = 1'b0;
  endtask

  // mode 0: ready held high; mode 1: ready pattern 1,0,0,1
  task automatic wait_log(input int n, input int mode);
    int b = 0;
    int j = 0;
    while (log_d.size() < n && b < 200) begin
      if (mode == 0) src_ready = 1'b1;
      else src_ready = (j % 4 == 0) || (j % 4 == 3);
      j++;
      b++;
      tick();
    end
    src_ready = 1'b1;
    chk("wait_log_timeout", int'(log_d.size() >= n), 1);
  endtask

  task automatic wait_idle();
    int b = 0;
    src_ready = 1'b1;
    sample_en = 1'b1;
    sink      = W'(1);
    while (busy && b < 200) begin
      b++;
      tick();
    end
    sample_en = 1'b0;
    chk("idle_timeout", int'(busy), 0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_valid"}, int'(src_valid), 0);
    chk({tag, "_sop"}, int'(src_sop), 0);
    chk({tag, "_eop"}, int'(src_eop), 0);
    chk({tag, "_data"}, int'(src_data), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_run"}, int'(run_idx), 0);
  endtask

  initial begin
    int base;
    int d0;
    int hits;
    reset     = 1'b1;
    start     = 1'b0;
    sample_en = 1'b0;
    sink      = '0;
    src_ready = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    reset = 1'b0;
    tick();

    // start with a coincident sample, frame 0..7, ready high
    base      = log_d.size();
    d0        = done_cnt;
    src_ready = 1'b1;
    start     = 1'b1;
    sample_en = 1'b1;
    sink      = W'(55);
    tick();
    start     = 1'b0;
    feed(0);
    wait_log(base + N, 0);
    for (int i = 0; i < N; i++) begin
      chk("t1_data", log_d[base + i], i);
      chk("t1_sop", log_sop[base + i], int'(i == 0));
      chk("t1_eop", log_eop[base + i], int'(i == N - 1));
    end
    chk("t1_consecutive", log_cyc[base + N - 1] - log_cyc[base], N - 1);

    // second run under ready pattern 1,0,0,1
    feed(100);
    wait_log(base + 2 * N, 1);
    for (int i = 0; i < N; i++) begin
      chk("t2_data", log_d[base + N + i], 100 + i);
      chk("t2_run", log_run[base + N + i], 1);
    end
    wait_idle();
    repeat (2) tick();
    chk("t2_count", log_d.size(), base + 2 * N);
    chk("t2_done", done_cnt - d0, 1);

    // two runs 10..17 and 20..27
    base = log_d.size();
    d0   = done_cnt;
    pulse_start();
    feed(10);
    wait_log(base + N, 0);
    feed(20);
    wait_log(base + 2 * N, 0);
    wait_idle();
    repeat (3) tick();
    for (int i = 0; i < N; i++) begin
      chk("t3_d0", log_d[base + i], 10 + i);
      chk("t3_r0", log_run[base + i], 0);
      chk("t3_d1", log_d[base + N + i], 20 + i);
      chk("t3_r1", log_run[base + N + i], 1);
    end
    chk("t3_done", done_cnt - d0, 1);
    chk("t3_busy", int'(busy), 0);

    // start and sample 99 injected mid-stream
    base = log_d.size();
    pulse_start();
    feed(30);
    wait_log(base + N, 0);
    feed(40);
    wait_log(base + N + 3, 0);
    start     = 1'b1;
    sample_en = 1'b1;
    sink      = W'(99);
    tick();
    start     = 1'b0;
    sample_en = 1'b0;
    wait_log(base + 2 * N, 0);
    wait_idle();
    repeat (5) tick();
    hits = 0;
    for (int i = base; i < log_d.size(); i++)
      if (log_d[i] == 99) hits++;
    chk("t4_no99", hits, 0);
    chk("t4_count", log_d.size(), base + 2 * N);
    chk("t4_busy", int'(busy), 0);

    // reset after the 5th captured sample
    pulse_start();
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1;
      sink      = W'(50 + i);
      tick();
    end
    sample_en = 1'b0;
    reset     = 1'b1;
    tick();
    reset     = 1'b0;
    chk_all_zero("t5_reset");
    base = log_d.size();
    pulse_start();
    feed(60);
    wait_log(base + N, 0);
    for (int i = 0; i < N; i++)
      chk("t5_data", log_d[base + i], 60 + i);
    chk("t5_sop", log_sop[base], 1);
    feed(70);
    wait_log(base + 2 * N, 0);
    wait_idle();

`ifdef FRAME_CAPTURE_OFFSET_BIN_EN
    base = log_d.size();
    pulse_start();
    sample_en = 1'b1;
    sink      = 14'h2000;
    tick();
    sink      = 14'h0000;
    tick();
    for (int i = 2; i < N; i++) begin
      sink = 14'h2000;
      tick();
    end
    sample_en = 1'b0;
    wait_log(base + N, 0);
    chk("t6_mid", log_d[base], 0);
    chk("t6_min", log_d[base + 1], int'(14'h2000));
    feed(0);
    wait_log(base + 2 * N, 0);
    wait_idle();
`endif

    for (int k = 0; k < 3000; k++) begin
      sample_en = 1'($urandom_range(0, 1));
      sink      = W'($urandom);
      src_ready = ($urandom_range(0, 9) < 7);
      start     = ($urandom_range(0, 29) == 0);
      reset     = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    wait_idle();
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/frame_capture.md
FRAME_CAPTURE -- requirements
Module: frame_capture

Interface
REQ-001 SHALL have parameter SINK_WIDTH, default 14, the antenna sample width in bits.
REQ-002 SHALL have parameter FFT_DEPTH, default 11, so that the frame length is N = 2^FFT_DEPTH samples.
REQ-003 SHALL have parameter RUNS, default 3, the number of frames captured per start.
REQ-004 SHALL have port clk, input, 1 bit: the single clock. All logic is on its rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port sample_en, input, 1 bit: one-cycle strobe marking a new valid sink sample.
REQ-007 SHALL have port sink, input, SINK_WIDTH bits: the antenna sample.
REQ-008 SHALL have port start, input, 1 bit: single-cycle request to begin a capture sequence.
REQ-009 SHALL have port src_data, output, SINK_WIDTH bits: signed frame sample sent to the FFT/phase stage.
REQ-010 SHALL have ports src_valid, src_sop and src_eop, outputs, 1 bit each: sample valid, first sample of frame, last sample of frame.
REQ-011 SHALL have port src_ready, input, 1 bit: downstream accepts the sample.
REQ-012 SHALL have port busy, output, 1 bit: a sequence is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse after the last frame is delivered.
REQ-014 SHALL have port run_idx, output, $clog2(RUNS+1) bits: index of the current run.

Function
REQ-015 SHALL implement the FSM states IDLE, CAPTURE, STREAM and FINISH.
REQ-016 SHALL, in IDLE, move to CAPTURE on start=1, with run_idx set to 0 and the write address set to 0.
REQ-017 SHALL, in CAPTURE, write sink to buffer[wr_addr] and increment wr_addr on each sample_en.
REQ-018 SHALL, in CAPTURE, move to STREAM on the cycle the write at address N-1 occurs.
REQ-019 SHALL stream buffer[0..N-1] in order while in STREAM, with a one-cycle RAM read latency.
REQ-020 SHALL assert the first src_valid no more than 2 cycles after entering STREAM.
REQ-021 SHALL complete a transfer only when src_valid=1 and src_ready=1 in the same cycle.
REQ-022 SHALL hold src_data, src_sop and src_eop stable while src_valid=1 and src_ready=0.
REQ-023 SHALL NOT deassert src_valid before the transfer completes.
REQ-024 SHALL assert src_sop only with sample 0 and src_eop only with sample N-1.
REQ-025 SHALL, when src_ready is held at 1, deliver one sample per cycle with no bubbles.
REQ-026 SHALL, on the eop transfer, go to CAPTURE with run_idx incremented when run_idx < RUNS-1, and to FINISH otherwise.
REQ-027 SHALL, in FINISH, pulse done for one cycle and then return to IDLE with run_idx set to 0.
REQ-028 SHALL assert busy in every state except IDLE.
REQ-029 SHALL ignore start while busy=1.
REQ-030 SHALL ignore sample_en outside CAPTURE; those samples are dropped and not buffered.
REQ-031 SHALL let the write and read addresses wrap naturally at FFT_DEPTH bits, with no extra terminal logic.
REQ-032 SHALL, when start and sample_en coincide in IDLE, NOT capture that sample; capture begins with the next sample_en.

Reset
REQ-033 SHALL, on reset=1, go to IDLE and set src_valid, src_sop, src_eop, busy and done to 0, with src_data, run_idx and both addresses set to 0.
REQ-034 SHALL, on reset mid-capture or mid-stream, abandon the partial frame, emit no eop, and clear nothing in the RAM contents.

Configuration
REQ-035 SHALL treat the FRAME_CAPTURE_OFFSET_BIN_EN macro as follows: when defined, sink is offset-binary and its MSB is inverted before the write, so src_data is two's complement.
REQ-036 SHALL, when FRAME_CAPTURE_OFFSET_BIN_EN is undefined, treat sink as two's complement and store it unmodified.

Structure
REQ-037 SHALL place the FSM state enum and the default parameter constants in package frame_capture_pkg.
REQ-038 SHALL use one sub-module, frame_ram: a simple dual-port RAM with N words of SINK_WIDTH bits and a registered read.

Verification
REQ-039 SHALL run benches with FFT_DEPTH=3 (N=8) and RUNS=2.
REQ-040 SHALL cover: start, then 8 sample_en with sink=0..7 and src_ready=1 -> src_data 0..7 on consecutive cycles, sop with 0, eop with 7.
REQ-041 SHALL cover: src_ready toggling 1,0,0,1 during stream -> no sample lost or duplicated, and data is held while src_ready=0.
REQ-042 SHALL cover: two runs with sink 10..17 then 20..27 -> run_idx 0 then 1, then a single done pulse, then busy=0.
REQ-043 SHALL cover: start asserted during STREAM, and sample_en during STREAM with sink=99 -> 99 is never output and no new sequence starts.
REQ-044 SHALL cover: reset after the 5th captured sample -> all outputs are 0 next cycle, and a fresh start re-captures from address 0.
REQ-045 SHALL cover: with FRAME_CAPTURE_OFFSET_BIN_EN defined and SINK_WIDTH=14, sink=14'h2000 -> src_data=0, and sink=14'h0000 -> src_data=-8192.
